// File: rtl/reg_file_if.sv
// Register file access bundle: two write ports, three read ports,
// PC feed for substitution and the registered write-collision flag.
interface reg_file_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic             we1;
  logic [AW-1:0]    wa1;
  logic [WIDTH-1:0] wd1;
  logic             we2;
  logic [AW-1:0]    wa2;
  logic [WIDTH-1:0] wd2;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [AW-1:0]    ra3;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] rd3;
  logic             wcol;

  modport master (
    output we1, wa1, wd1,
    output we2, wa2, wd2,
    output ra1, ra2, ra3, pc_in,
    input  rd1, rd2, rd3, wcol
  );

  modport slave (
    input  we1, wa1, wd1,
    input  we2, wa2, wd2,
    input  ra1, ra2, ra3, pc_in,
    output rd1, rd2, rd3, wcol
  );
endinterface

// File: rtl/reg_file.sv
// Multi-port GPR file: DEPTH x WIDTH flops, 3 comb reads, 2 writes.
// Ports: clk, rst (sync, active-low), bus (reg_file_if.slave).
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int PC_IDX = 15
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  localparam bit PC_EN = (PC_IDX < DEPTH);

  if (DEPTH < 2 || DEPTH > (1 << AW)) begin : g_bad_cfg
    $error("reg_file: DEPTH must be in 2..2**AW");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic             ok1;
  logic             ok2;
  logic             wcol_q;

  // The PC entry belongs to fetch, so writes to it are dropped.
  assign ok1 = bus.we1
            && (int'(bus.wa1) < DEPTH)
            && (int'(bus.wa1) != PC_IDX);
  assign ok2 = bus.we2
            && (int'(bus.wa2) < DEPTH)
            && (int'(bus.wa2) != PC_IDX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wcol_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ok2 && int'(bus.wa2) == i) begin
          mem[i] <= bus.wd2;
        end else if (ok1 && int'(bus.wa1) == i) begin
          mem[i] <= bus.wd1;
        end
      end
      wcol_q <= ok1 && ok2 && (bus.wa1 == bus.wa2);
    end
  end

  assign bus.wcol = wcol_q;

  for (genvar p = 0; p < 3; p++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] v;

    assign a = (p == 0) ? bus.ra1 :
               (p == 1) ? bus.ra2 : bus.ra3;

    // Port 2 bypass wins over port 1, matching the write priority.
    always_comb begin
      v = '0;
      if (PC_EN && int'(a) == PC_IDX) begin
        v = bus.pc_in;
      end else if (int'(a) >= DEPTH) begin
        v = '0;
      end else if (rst && bus.we2 && bus.wa2 == a) begin
        v = bus.wd2;
      end else if (rst && bus.we1 && bus.wa1 == a) begin
        v = bus.wd1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (int'(a) == i) begin
            v = mem[i];
          end
        end
      end
    end
  end

  assign bus.rd1 = g_rd[0].v;
  assign bus.rd2 = g_rd[1].v;
  assign bus.rd3 = g_rd[2].v;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: vector table plus reset, mid-reset and a
// narrow no-PC configuration.
module tb_reg_file;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_file_if #(.WIDTH(32), .AW(4)) b();
  reg_file_if #(.WIDTH(8),  .AW(4)) s();

  reg_file #(
    .WIDTH(32), .DEPTH(16), .AW(4), .PC_IDX(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(b.slave)
  );

  reg_file #(
    .WIDTH(8), .DEPTH(12), .AW(4), .PC_IDX(16)
  ) dut_s (
    .clk(clk),
    .rst(rst),
    .bus(s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we1;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic        we2;
    logic [3:0]  wa2;
    logic [31:0] wd2;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  ra3;
    logic [31:0] pc;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] e3;
    logic        ew;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic idle_b();
    b.we1 = 1'b0; b.wa1 = '0; b.wd1 = '0;
    b.we2 = 1'b0; b.wa2 = '0; b.wd2 = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    tbl[0]  = '{1'b1, 4'd5,  32'd100,
                1'b0, 4'd0,  32'd0,
                4'd5, 4'd0, 4'd5, 32'd0,
                32'd100, 32'd0, 32'd100, 1'b0};
    tbl[1]  = '{1'b0, 4'd5,  32'd1234,
                1'b0, 4'd0,  32'd0,
                4'd5, 4'd5, 4'd3, 32'd0,
                32'd100, 32'd100, 32'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'd7,  32'h1111_1111,
                1'b1, 4'd7,  32'h2222_2222,
                4'd7, 4'd5, 4'd7, 32'd0,
                32'h2222_2222, 32'd100, 32'h2222_2222, 1'b0};
    tbl[3]  = '{1'b0, 4'd0,  32'd0,
                1'b0, 4'd0,  32'd0,
                4'd7, 4'd7, 4'd0, 32'd0,
                32'h2222_2222, 32'h2222_2222, 32'd0, 1'b1};
    tbl[4]  = '{1'b0, 4'd0,  32'd0,
                1'b0, 4'd0,  32'd0,
                4'd7, 4'd0, 4'd0, 32'd0,
                32'h2222_2222, 32'd0, 32'd0, 1'b0};
    tbl[5]  = '{1'b1, 4'd15, 32'hFFFF_FFFF,
                1'b0, 4'd0,  32'd0,
                4'd15, 4'd15, 4'd7, 32'h0000_8008,
                32'h0000_8008, 32'h0000_8008, 32'h2222_2222, 1'b0};
    tbl[6]  = '{1'b0, 4'd0,  32'd0,
                1'b0, 4'd0,  32'd0,
                4'd0, 4'd15, 4'd0, 32'h0000_8008,
                32'd0, 32'h0000_8008, 32'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'd0,  32'd0,
                1'b0, 4'd0,  32'd0,
                4'd15, 4'd15, 4'd14, 32'd0,
                32'd0, 32'd0, 32'd0, 1'b0};
    tbl[8]  = '{1'b1, 4'd1,  32'hAAAA_0001,
                1'b1, 4'd2,  32'hA5A5_A5A5,
                4'd1, 4'd2, 4'd2, 32'd0,
                32'hAAAA_0001, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
    tbl[9]  = '{1'b0, 4'd0,  32'd0,
                1'b0, 4'd0,  32'd0,
                4'd1, 4'd2, 4'd5, 32'd0,
                32'hAAAA_0001, 32'hA5A5_A5A5, 32'd100, 1'b0};
    tbl[10] = '{1'b1, 4'd15, 32'h0BAD_0001,
                1'b1, 4'd15, 32'h0BAD_0002,
                4'd15, 4'd1, 4'd7, 32'd0,
                32'd0, 32'hAAAA_0001, 32'h2222_2222, 1'b0};
    tbl[11] = '{1'b0, 4'd0,  32'd0,
                1'b0, 4'd0,  32'd0,
                4'd15, 4'd15, 4'd2, 32'd0,
                32'd0, 32'd0, 32'hA5A5_A5A5, 1'b0};
    tbl[12] = '{1'b1, 4'd4,  32'd44,
                1'b1, 4'd9,  32'd9,
                4'd9, 4'd4, 4'd9, 32'd0,
                32'd9, 32'd44, 32'd9, 1'b0};
    tbl[13] = '{1'b0, 4'd0,  32'd0,
                1'b0, 4'd0,  32'd0,
                4'd9, 4'd4, 4'd9, 32'd0,
                32'd9, 32'd44, 32'd9, 1'b0};

    // Reset held for two edges while port 1 tries to write r3.
    rst = 1'b0;
    idle_b();
    b.we1 = 1'b1; b.wa1 = 4'd3; b.wd1 = 32'hDEAD_BEEF;
    b.ra1 = '0; b.ra2 = '0; b.ra3 = '0; b.pc_in = '0;
    s.we1 = 1'b0; s.wa1 = '0; s.wd1 = '0;
    s.we2 = 1'b0; s.wa2 = '0; s.wd2 = '0;
    s.ra1 = '0; s.ra2 = '0; s.ra3 = '0; s.pc_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_wcol", {31'd0, b.wcol}, 32'd0);
    for (int r = 0; r < 15; r++) begin
      b.ra1 = 4'(r); b.ra2 = 4'(r); b.ra3 = 4'(r);
      #1;
      chk($sformatf("reset_rd1_r%0d", r), b.rd1, 32'd0);
      chk($sformatf("reset_rd2_r%0d", r), b.rd2, 32'd0);
      chk($sformatf("reset_rd3_r%0d", r), b.rd3, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    idle_b();

    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      b.we1 = tbl[k].we1; b.wa1 = tbl[k].wa1; b.wd1 = tbl[k].wd1;
      b.we2 = tbl[k].we2; b.wa2 = tbl[k].wa2; b.wd2 = tbl[k].wd2;
      b.ra1 = tbl[k].ra1; b.ra2 = tbl[k].ra2; b.ra3 = tbl[k].ra3;
      b.pc_in = tbl[k].pc;
      #1;
      chk($sformatf("v%0d_rd1", k), b.rd1, tbl[k].e1);
      chk($sformatf("v%0d_rd2", k), b.rd2, tbl[k].e2);
      chk($sformatf("v%0d_rd3", k), b.rd3, tbl[k].e3);
      chk($sformatf("v%0d_wcol", k), {31'd0, b.wcol}, {31'd0, tbl[k].ew});
    end

    // Reset mid-operation: no bypass of the discarded write.
    @(negedge clk);
    idle_b();
    rst = 1'b0;
    b.we2 = 1'b1; b.wa2 = 4'd2; b.wd2 = 32'h5A5A_5A5A;
    b.ra1 = 4'd5; b.ra2 = 4'd9; b.ra3 = 4'd2; b.pc_in = '0;
    #1;
    chk("midrst_pre_rd3", b.rd3, 32'hA5A5_A5A5);
    chk("midrst_pre_rd1", b.rd1, 32'd100);
    @(negedge clk);
    #1;
    chk("midrst_post_rd3", b.rd3, 32'd0);
    chk("midrst_post_rd1", b.rd1, 32'd0);
    chk("midrst_post_rd2", b.rd2, 32'd0);
    rst = 1'b1;
    idle_b();
    @(negedge clk);
    #1;
    chk("midrst_after_rd3", b.rd3, 32'd0);

    // Narrow configuration: DEPTH=12, PC substitution disabled.
    s.we1 = 1'b1; s.wa1 = 4'd11; s.wd1 = 8'h3C;
    @(negedge clk);
    s.we1 = 1'b1; s.wa1 = 4'd13; s.wd1 = 8'hFF;
    s.ra1 = 4'd13; s.ra2 = 4'd11; s.ra3 = 4'd15; s.pc_in = 8'hAA;
    #1;
    chk("s_pre_r13", {24'd0, s.rd1}, 32'd0);
    chk("s_pre_r11", {24'd0, s.rd2}, 32'h3C);
    chk("s_pre_r15", {24'd0, s.rd3}, 32'd0);
    @(negedge clk);
    s.we1 = 1'b0;
    #1;
    chk("s_post_r13", {24'd0, s.rd1}, 32'd0);
    chk("s_post_r11", {24'd0, s.rd2}, 32'h3C);
    chk("s_post_r15", {24'd0, s.rd3}, 32'd0);
    s.we1 = 1'b1; s.wa1 = 4'd11; s.wd1 = 8'h7F;
    @(negedge clk);
    s.we1 = 1'b0; s.wd1 = 8'h00;
    #1;
    chk("s_r11_7f", {24'd0, s.rd2}, 32'h7F);
    chk("s_wcol", {31'd0, s.wcol}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
